// File: rtl/bcp_assign_ctrl.sv
// bcp_assign_ctrl: assignment controller for the hardware BCP engine.
// Takes a batch of implied literals over NVAR variable slots, walks them
// through an external combinational priority encoder (highest slot first),
// commits one assignment per cycle, flags conflicts and keeps a trail
// stack so backtracking can undo committed variables.
//
// Optional feature macro: BCP_TRAIL_EN (trail stack + backtrack). When it is
// undefined there is no trail storage, trail_cnt is 0 and bt_req is ignored.
//
// Ports:
//   clock, reset_n        rising-edge clock, async active-low reset
//   clr                   synchronous clear of everything (highest priority)
//   imp_valid/imp_ready   implication batch handshake (ready only in IDLE)
//   imp_req, imp_pol      implied variables and their values
//   pe_en, pe_in, pe_out  encoder enable, pending vector, encoded index
//   asg_set, asg_val      per-variable assigned flag and value
//   asg_valid, asg_idx    commit pulse and committed index
//   conflict, conf_idx    sticky conflict flag and offending variable
//   done                  batch completed without conflict (pulse)
//   bt_req, trail_cnt     backtrack pop request, trail occupancy
module bcp_assign_ctrl #(
    parameter int unsigned NVAR = 8,
    parameter int unsigned IDXW = 3
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            clr,
    input  logic            imp_valid,
    output logic            imp_ready,
    input  logic [NVAR-1:0] imp_req,
    input  logic [NVAR-1:0] imp_pol,
    output logic            pe_en,
    output logic [NVAR-1:0] pe_in,
    input  logic [IDXW-1:0] pe_out,
    output logic [NVAR-1:0] asg_set,
    output logic [NVAR-1:0] asg_val,
    output logic            asg_valid,
    output logic [IDXW-1:0] asg_idx,
    output logic            conflict,
    output logic [IDXW-1:0] conf_idx,
    output logic            done,
    input  logic            bt_req,
    output logic [IDXW:0]   trail_cnt
);

    localparam int unsigned CNTW = IDXW + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCAN     = 2'd1,
        ST_CONFLICT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [NVAR-1:0]   pending_q, pending_d;
    logic [NVAR-1:0]   pol_q, pol_d;
    logic [NVAR-1:0]   asg_set_q, asg_set_d;
    logic [NVAR-1:0]   asg_val_q, asg_val_d;
    logic              asg_valid_q, asg_valid_d;
    logic [IDXW-1:0]   asg_idx_q, asg_idx_d;
    logic              conflict_q, conflict_d;
    logic [IDXW-1:0]   conf_idx_q, conf_idx_d;
    logic              done_q, done_d;
    logic              imp_ready_q, imp_ready_d;
    logic              pe_en_q, pe_en_d;
    logic              push_c;
    logic              pop_c;
    logic              bt_en_c;

`ifdef BCP_TRAIL_EN
    logic [IDXW-1:0]   trail_q [NVAR];
    logic [IDXW-1:0]   trail_d [NVAR];
    logic [CNTW-1:0]   trail_cnt_q, trail_cnt_d;

    assign bt_en_c   = bt_req;
    assign trail_cnt = trail_cnt_q;
`else
    logic bt_req_unused;
    logic push_unused;
    logic pop_unused;

    assign bt_req_unused = bt_req;
    assign push_unused   = push_c;
    assign pop_unused    = pop_c;
    assign bt_en_c       = 1'b0;
    assign trail_cnt     = CNTW'(0);
`endif

    // State register and all registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            pol_q       <= '0;
            asg_set_q   <= '0;
            asg_val_q   <= '0;
            asg_valid_q <= 1'b0;
            asg_idx_q   <= '0;
            conflict_q  <= 1'b0;
            conf_idx_q  <= '0;
            done_q      <= 1'b0;
            imp_ready_q <= 1'b1;
            pe_en_q     <= 1'b0;
`ifdef BCP_TRAIL_EN
            trail_cnt_q <= '0;
            for (int unsigned i = 0; i < NVAR; i++) trail_q[i] <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            pol_q       <= pol_d;
            asg_set_q   <= asg_set_d;
            asg_val_q   <= asg_val_d;
            asg_valid_q <= asg_valid_d;
            asg_idx_q   <= asg_idx_d;
            conflict_q  <= conflict_d;
            conf_idx_q  <= conf_idx_d;
            done_q      <= done_d;
            imp_ready_q <= imp_ready_d;
            pe_en_q     <= pe_en_d;
`ifdef BCP_TRAIL_EN
            trail_cnt_q <= trail_cnt_d;
            trail_q     <= trail_d;
`endif
        end
    end

    // Next-state, commit/conflict decisions and trail bookkeeping
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        pol_d       = pol_q;
        asg_set_d   = asg_set_q;
        asg_val_d   = asg_val_q;
        asg_valid_d = 1'b0;
        asg_idx_d   = asg_idx_q;
        conflict_d  = conflict_q;
        conf_idx_d  = conf_idx_q;
        done_d      = 1'b0;
        push_c      = 1'b0;
        pop_c       = 1'b0;
`ifdef BCP_TRAIL_EN
        trail_d     = trail_q;
        trail_cnt_d = trail_cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (imp_valid) begin
                    pending_d = imp_req;
                    pol_d     = imp_pol;
                    state_d   = ST_SCAN;
                end
                pop_c = bt_en_c;
            end
            ST_SCAN: begin
                if (pending_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (asg_set_q[pe_out]) begin
                    if (asg_val_q[pe_out] != pol_q[pe_out]) begin
                        conflict_d = 1'b1;
                        conf_idx_d = pe_out;
                        pending_d  = '0;
                        state_d    = ST_CONFLICT;
                    end else begin
                        // Same value already assigned: drop it silently
                        pending_d[pe_out] = 1'b0;
                    end
                end else begin
                    asg_set_d[pe_out] = 1'b1;
                    asg_val_d[pe_out] = pol_q[pe_out];
                    asg_valid_d       = 1'b1;
                    asg_idx_d         = pe_out;
                    pending_d[pe_out] = 1'b0;
                    push_c            = 1'b1;
                end
            end
            ST_CONFLICT: begin
                if (bt_en_c) begin
                    pop_c      = 1'b1;
                    conflict_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef BCP_TRAIL_EN
        // Push and pop never coincide: pushes happen only in SCAN
        if (push_c) begin
            trail_d[trail_cnt_q[IDXW-1:0]] = pe_out;
            trail_cnt_d = trail_cnt_q + CNTW'(1);
        end
        if (pop_c && (trail_cnt_q != '0)) begin
            asg_set_d[trail_q[IDXW'(trail_cnt_q - CNTW'(1))]] = 1'b0;
            trail_cnt_d = trail_cnt_q - CNTW'(1);
        end
`endif

        if (clr) begin
            state_d     = ST_IDLE;
            pending_d   = '0;
            pol_d       = '0;
            asg_set_d   = '0;
            asg_val_d   = '0;
            asg_valid_d = 1'b0;
            asg_idx_d   = '0;
            conflict_d  = 1'b0;
            conf_idx_d  = '0;
            done_d      = 1'b0;
`ifdef BCP_TRAIL_EN
            trail_cnt_d = '0;
            for (int unsigned i = 0; i < NVAR; i++) trail_d[i] = '0;
`endif
        end

        imp_ready_d = (state_d == ST_IDLE);
        pe_en_d     = (state_d == ST_SCAN);
    end

    assign imp_ready = imp_ready_q;
    assign pe_en     = pe_en_q;
    assign pe_in     = pending_q;
    assign asg_set   = asg_set_q;
    assign asg_val   = asg_val_q;
    assign asg_valid = asg_valid_q;
    assign asg_idx   = asg_idx_q;
    assign conflict  = conflict_q;
    assign conf_idx  = conf_idx_q;
    assign done      = done_q;

endmodule
